mcp9808_sampler: RTL
====================

// Module: mcp9808_sampler
// PURPOSE
//  Downstream/control stage for the mcp9808 interface: schedules periodic or one-shot reads,
//  drives its update/ready handshake, captures the result as a signed sample. Tracks
//  min/max, latches comparator flags, flags a stalled interface, optionally block-averages.
//  Sits between mcp9808 and display/logging logic.
// PARAMETERS
//  SAMPLE_PERIOD  100_000_000  clk cycles between automatic sample requests (>=16)
//  TIMEOUT        1_000_000    max clk cycles waiting on either ready edge before abort
//  AVG_LOG2       3            log2 of samples per block average (1..6)
// PORTS
//  clk              in   1   system clock, all logic on posedge
//  rst              in   1   synchronous, active-high reset
//  enable_i         in   1   1 = periodic sampling active
//  sample_now_i     in   1   one-cycle pulse: request one sample (honoured only in IDLE)
//  clear_i          in   1   one-cycle pulse: clear min/max, timeout_o, avg accumulator
//  dev_update_o     out  1   to mcp9808 update
//  dev_ready_i      in   1   from mcp9808 ready
//  dev_temp_val_i   in   12  from mcp9808 tempVal
//  dev_temp_sign_i  in   1   from mcp9808 tempSign
//  dev_temp_comp_i  in   3   from mcp9808 tempComp {crit,upper,lower}
//  sample_o         out  13  signed {sign,val}, two's complement, LSB = 0.0625 C
//  sample_valid_o   out  1   one-cycle pulse, sample_o/alert_o new
//  alert_o          out  3   tempComp captured with sample
//  min_o, max_o     out  13  signed extremes since reset/clear
//  timeout_o        out  1   sticky; set on handshake timeout
//  busy_o           out  1   FSM not IDLE
//  avg_o            out  13  signed block average (TEMP_AVG_EN only)
//  avg_valid_o      out  1   one-cycle pulse with new avg_o (TEMP_AVG_EN only)
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; period counter 0; min/max "empty".
//  Period counter: free-running 0..SAMPLE_PERIOD-1 while enable_i; tick at wrap; held at 0
//   when enable_i=0. Tick or sample_now_i outside IDLE is dropped (no queueing).
//  FSM: IDLE -(tick&enable_i | sample_now_i)-> REQ
//   REQ: dev_update_o=1 only while dev_ready_i=1; -> WAIT_BUSY next cycle after the update cycle
//   WAIT_BUSY: -(dev_ready_i=0)-> WAIT_DONE
//   WAIT_DONE: -(dev_ready_i=1)-> CAPTURE
//   CAPTURE: 1 cycle, registers outputs, -> IDLE
//  dev_update_o is a single-cycle pulse per request, never asserted outside REQ.
//  Timeout: counter clears on entry to WAIT_BUSY and WAIT_DONE; reaching TIMEOUT in either
//   -> timeout_o=1, IDLE, no sample. REQ waits unbounded for ready (no timeout).
//  Capture: sample_o={dev_temp_sign_i,dev_temp_val_i}, alert_o=dev_temp_comp_i, sampled
//   in CAPTURE; sample_valid_o high the cycle after CAPTURE (exactly 1 cycle).
//  Min/max: signed compare, updated the cycle after sample_valid_o; first sample after
//   reset/clear loads both. clear_i coincident with a sample: clear wins, that sample then
//   loads min/max as first sample. clear_i never aborts the FSM.
//  Reset mid-transaction: dev_update_o drops same edge, FSM IDLE, no sample emitted.
// CONFIGURATION
//  TEMP_AVG_EN defined: signed accumulator (13+AVG_LOG2 bits) sums samples; after 2^AVG_LOG2
//   samples avg_o = acc >>> AVG_LOG2 (arithmetic, truncation toward -inf), avg_valid_o
//   pulses one cycle after the final sample_valid_o, accumulator and count restart.
//   clear_i discards partial block.
//  TEMP_AVG_EN undefined: no accumulator logic; avg_o=0, avg_valid_o=0 constant.
// STRUCTURE
//  Package mcp9808_pkg: FSM state encoding, TEMP_W=13, COMP_W=3, comp bit indices.
//  Sub-module mcp9808_avg_acc (accumulator/counter/shift), instantiated only under TEMP_AVG_EN.
// TESTING (bench models mcp9808 handshake: ready falls 3 cycles after update, rises N later)
//  sample_now_i, device returns val=0x195 sign=0 -> one update pulse, sample_o=0x0195, valid 1 cyc
//  enable_i, SAMPLE_PERIOD=32 -> update pulses exactly every 32 cycles with fast device
//  samples +0x190,-0x010(0x1FF0),+0x050 -> min_o=0x1FF0, max_o=0x0190; clear_i -> next loads both
//  device never drops ready after update, TIMEOUT=64 -> timeout_o=1 at cycle 64, busy_o=0, no valid
//  rst asserted in WAIT_DONE -> dev_update_o=0, outputs 0, no valid after ready rises
//  TEMP_AVG_EN, AVG_LOG2=2, samples 4,5,6,-3 -> avg_o=3 (12>>>2), avg_valid_o one pulse

Source files
------------

// File: rtl/mcp9808_pkg.sv
// Shared types and constants for the mcp9808 sampler.
// State encoding, sample/comparator widths and flag bit positions.
package mcp9808_pkg;

  localparam int TEMP_W = 13;
  localparam int VAL_W  = 12;
  localparam int COMP_W = 3;

  localparam int COMP_CRIT  = 2;
  localparam int COMP_UPPER = 1;
  localparam int COMP_LOWER = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_CAPTURE
  } state_e;

endpackage

// File: rtl/mcp9808_avg_acc.sv
// Block averager for the mcp9808 sampler: sums 2^AVG_LOG2 samples,
// emits the floor-divided mean, then restarts. Built only with TEMP_AVG_EN.
module mcp9808_avg_acc
  import mcp9808_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              sample_valid_i,
  input  logic [TEMP_W-1:0] sample_i,
  output logic [TEMP_W-1:0] avg_o,
  output logic              avg_valid_o
);

  localparam int ACC_W = TEMP_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    acc_base;
  logic [ACC_W-1:0]    sum;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [AVG_LOG2-1:0] cnt_base;
  logic [TEMP_W-1:0]   avg_q, avg_d;
  logic                avg_v_q, avg_v_d;

  // A clear in the same cycle as a sample drops the old block first,
  // so that sample becomes the first of a fresh block.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    avg_d    = avg_q;
    avg_v_d  = 1'b0;
    acc_base = clear_i ? '0 : acc_q;
    cnt_base = clear_i ? '0 : cnt_q;
    sum      = acc_base
             + {{AVG_LOG2{sample_i[TEMP_W-1]}}, sample_i};
    if (sample_valid_i) begin
      if (cnt_base == '1) begin
        avg_d   = sum[ACC_W-1:AVG_LOG2];
        avg_v_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_base + 1'b1;
      end
    end else if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  // Accumulator, block counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      avg_v_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      avg_v_q <= avg_v_d;
    end
  end

  assign avg_o       = avg_q;
  assign avg_valid_o = avg_v_q;

endmodule

// File: rtl/mcp9808_sampler.sv
// Control stage for the mcp9808: schedules reads, runs the update/ready
// handshake, captures signed samples, min/max. Macro TEMP_AVG_EN adds averaging.
module mcp9808_sampler
  import mcp9808_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 100_000_000,
  parameter int TIMEOUT       = 1_000_000,
  parameter int AVG_LOG2      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              sample_now_i,
  input  logic              clear_i,
  output logic              dev_update_o,
  input  logic              dev_ready_i,
  input  logic [VAL_W-1:0]  dev_temp_val_i,
  input  logic              dev_temp_sign_i,
  input  logic [COMP_W-1:0] dev_temp_comp_i,
  output logic [TEMP_W-1:0] sample_o,
  output logic              sample_valid_o,
  output logic [COMP_W-1:0] alert_o,
  output logic [TEMP_W-1:0] min_o,
  output logic [TEMP_W-1:0] max_o,
  output logic              timeout_o,
  output logic              busy_o,
  output logic [TEMP_W-1:0] avg_o,
  output logic              avg_valid_o
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e state_q, state_d;

  logic [PW-1:0]     per_q, per_d;
  logic              tick;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              tmo_last;
  logic              upd;
  logic              cap;
  logic              to_hit;

  logic [TEMP_W-1:0] sample_q;
  logic [COMP_W-1:0] alert_q;
  logic              valid_q;
  logic [TEMP_W-1:0] min_q, max_q;
  logic              empty_q;
  logic              timeout_q;

  assign tick     = enable_i && (per_q == PW'(SAMPLE_PERIOD - 1));
  assign tmo_last = (tmo_q == TW'(TIMEOUT - 1));

  // Period counter wraps while enabled and parks at zero otherwise.
  always_comb begin
    per_d = per_q + 1'b1;
    if (!enable_i || tick) begin
      per_d = '0;
    end
  end

  // Next-state logic; update is only driven while the device is ready.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    upd     = 1'b0;
    cap     = 1'b0;
    to_hit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tick || sample_now_i) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dev_ready_i) begin
          upd     = 1'b1;
          tmo_d   = '0;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!dev_ready_i) begin
          tmo_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (tmo_last) begin
          to_hit  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (dev_ready_i) begin
          state_d = ST_CAPTURE;
        end else if (tmo_last) begin
          to_hit  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        cap     = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, period and timeout counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      per_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      tmo_q   <= tmo_d;
    end
  end

  // Sample capture; valid is the registered CAPTURE strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
      alert_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= cap;
      if (cap) begin
        sample_q <= {dev_temp_sign_i, dev_temp_val_i};
        alert_q  <= dev_temp_comp_i;
      end
    end
  end

  // Min/max tracking; a coincident clear makes this sample the first.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q   <= '0;
      max_q   <= '0;
      empty_q <= 1'b1;
    end else if (valid_q) begin
      empty_q <= 1'b0;
      if (clear_i || empty_q) begin
        min_q <= sample_q;
        max_q <= sample_q;
      end else begin
        if ($signed(sample_q) < $signed(min_q)) begin
          min_q <= sample_q;
        end
        if ($signed(sample_q) > $signed(max_q)) begin
          max_q <= sample_q;
        end
      end
    end else if (clear_i) begin
      min_q   <= '0;
      max_q   <= '0;
      empty_q <= 1'b1;
    end
  end

  // Sticky timeout flag; a new timeout outranks a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (to_hit) begin
      timeout_q <= 1'b1;
    end else if (clear_i) begin
      timeout_q <= 1'b0;
    end
  end

`ifdef TEMP_AVG_EN
  mcp9808_avg_acc #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (clear_i),
    .sample_valid_i(valid_q),
    .sample_i      (sample_q),
    .avg_o         (avg_o),
    .avg_valid_o   (avg_valid_o)
  );
`else
  assign avg_o       = '0;
  assign avg_valid_o = 1'b0;
`endif

  assign dev_update_o   = upd;
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign alert_o        = alert_q;
  assign min_o          = min_q;
  assign max_o          = max_q;
  assign timeout_o      = timeout_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule
